prog_loader: RTL

- Writer side of the instruction memory: receives a program image as a byte stream and writes 32-bit instruction words into a writable instruction RAM.
- Sits between the UART receiver and the instruction RAM write port.
- Holds the CPU in reset (`cpu_hold`) until the image is loaded, then releases it so fetch starts at `BASE_ADDR` (the jump vector at word 0).

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_byte_to_word.sv | 33 +++
 rtl/prog_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Byte-stream to word assembler: shifts bytes in MSB first and flags the
// cycle in which the last byte of a word arrives.
module byte_to_word
  import prog_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  output logic                    word_valid_o,
  output logic [8*WORD_BYTES-1:0] word_o
);

  logic [8*(WORD_BYTES-1)-1:0] shift_q;
  logic [BYTE_IDX_W-1:0]       idx_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (valid_i) begin
      shift_q <= {shift_q[8*(WORD_BYTES-2)-1:0], data_i};
      idx_q   <= idx_q + BYTE_IDX_W'(1);
    end
  end

  // The last byte bypasses the register so the word is ready in its own cycle.
  assign word_valid_o = valid_i && (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));
  assign word_o       = {shift_q, data_i};

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a length-prefixed byte image into instruction RAM
// writes and holds the CPU until done. Checksum stage: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  rx_len;
  logic              len_over;
  logic              asm_valid;
  logic              word_valid;
  logic [31:0]       word;
  logic              last_word;
  logic              mem_we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  assign rx_len    = {len_hi_q, rx_data};
  assign len_over  = 32'(rx_len) > (32'd1 << ADDR_W);
  assign asm_valid = rx_valid && (state_q == DATA);
  assign last_word = word_valid && ((cnt_q + LEN_W'(1)) == len_q);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CHK;

  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (asm_valid) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`else
  localparam state_e AFTER_DATA = DONE;
`endif

  byte_to_word u_asm (
    .clk          (clk),
    .reset        (reset),
    .data_i       (rx_data),
    .valid_i      (asm_valid),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_HI: if (rx_valid) state_d = LEN_LO;
      LEN_LO: begin
        if (rx_valid) begin
          if (rx_len == '0) begin
            state_d = AFTER_DATA;
          end else if (len_over) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: if (last_word) state_d = AFTER_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
`endif
      default: state_d = state_q;
    endcase
  end

  // Status flags trail the state by a cycle so the final write lands before release.
  always_comb begin
    hold_d  = (state_q != DONE);
    done_d  = (state_q == DONE);
    error_d = (state_q == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == LEN_HI && rx_valid) len_hi_q <= rx_data;
      if (state_q == LEN_LO && rx_valid) len_q    <= rx_len;
      if (word_valid) begin
        cnt_q   <= cnt_q + LEN_W'(1);
        wdata_q <= word;
      end
      mem_we_q <= word_valid;
      if (mem_we_q) addr_q <= addr_q + 32'd4;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
